alu_pipe: RTL
=============

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, which sets the operand and result width in bits; legal range is 2..64.
REQ-002 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The module SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 The module SHALL have port in_valid, input, 1 bit: the operand set is presented.
REQ-005 The module SHALL have port in_ready, output, 1 bit: the block accepts an operand set this cycle.
REQ-006 The module SHALL have port a, input, WIDTH bits: operand A.
REQ-007 The module SHALL have port b, input, WIDTH bits: operand B.
REQ-008 The module SHALL have port op, input, 3 bits, with encoding 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 NAND, 110 SLT, 111 MUL.
REQ-009 The module SHALL have port out_valid, output, 1 bit: result and flags are valid.
REQ-010 The module SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 The module SHALL have port result, output, WIDTH bits: the registered result.
REQ-012 The module SHALL have port flag_z, output, 1 bit: result equals 0.
REQ-013 The module SHALL have port flag_n, output, 1 bit: result[WIDTH-1].
REQ-014 The module SHALL have port flag_c, output, 1 bit: carry, borrow or MUL overflow.
REQ-015 The module SHALL have port flag_v, output, 1 bit: signed overflow.

Function
REQ-016 The block SHALL accept an operand set only on a rising edge where in_valid and in_ready are both 1 (a handshake).
REQ-017 The block SHALL complete a handshake on the output side only on a rising edge where out_valid and out_ready are both 1.
REQ-018 The block SHALL drive in_ready = 1 only when state is IDLE and (out_valid = 0 or out_ready = 1), and only while rst_n = 1.
REQ-019 The block SHALL implement exactly three states: IDLE, MUL_RUN and MUL_WAIT.
REQ-020 For ops other than MUL, the block SHALL load result and flags into the output register on the acceptance edge, so that out_valid = 1 in the next cycle (latency 1), with sustained throughput of 1 per cycle while out_ready = 1.
REQ-021 ADD/SUB SHALL compute modulo 2^WIDTH.
REQ-022 For ADD, flag_c SHALL be the carry out; for SUB, flag_c SHALL be the borrow (a < b unsigned).
REQ-023 For ADD/SUB, flag_v SHALL be two's-complement overflow.
REQ-024 AND, OR, XOR and NAND SHALL be bitwise and SHALL set flag_c = flag_v = 0.
REQ-025 SLT SHALL output result = 1 if signed a < signed b, otherwise 0, and SHALL set flag_c = flag_v = 0.
REQ-026 MUL SHALL be unsigned and iterative shift-add, one partial product per cycle; result SHALL be the low WIDTH bits of a*b.
REQ-027 For MUL, flag_c SHALL be 1 if and only if the high WIDTH bits of the product are non-zero, and flag_v SHALL be 0.
REQ-028 For every op, flag_z and flag_n SHALL be derived from the final result.
REQ-029 On MUL acceptance, the state SHALL go IDLE -> MUL_RUN and the operands SHALL be latched; MUL_RUN SHALL last exactly WIDTH cycles, with the iteration counter counting 0..WIDTH-1.
REQ-030 After the final iteration, if the output register is free (out_valid = 0 or out_ready = 1), the product SHALL load and the state SHALL return to IDLE; otherwise the state SHALL go to MUL_WAIT.
REQ-031 MUL_WAIT SHALL hold the product and load it on the first edge the output register is free, then return to IDLE.
REQ-032 Best-case MUL latency SHALL be out_valid = 1 exactly WIDTH+1 cycles after the acceptance edge.
REQ-033 in_ready SHALL be 0 throughout MUL_RUN and MUL_WAIT, and in_valid SHALL be ignored in those states.
REQ-034 While out_valid = 1 and out_ready = 0, result and all flags SHALL hold stable and in_ready SHALL be 0.
REQ-035 out_valid SHALL fall on an output-handshake edge unless a new result loads on that same edge, in which case out_valid SHALL stay 1 with the new data.
REQ-036 Changes to a, b or op after acceptance SHALL have no effect on the in-flight operation.

Reset
REQ-037 While rst_n = 0, the block SHALL hold state = IDLE, clear the counter and operand latches, and drive out_valid, result, flag_z, flag_n, flag_c, flag_v and in_ready to 0.
REQ-038 Reset asserted mid-MUL SHALL abandon the operation with no result produced; the first cycle after release SHALL show in_ready = 1.

Verification (WIDTH = 8 unless noted)
REQ-039 The bench SHALL verify: ADD a=0x0A, b=0x03, out_ready=1 -> next cycle result=0x0D, z=0, n=0, c=0, v=0; back-to-back ADD, SUB, AND, OR, XOR, NAND -> 0x0D, 0x07, 0x02, 0x0B, 0x09, 0xFD on consecutive cycles.
REQ-040 The bench SHALL verify the arithmetic edge cases: SUB 0x03-0x0A -> 0xF9, c=1, n=1, v=0; ADD 0x7F+0x01 -> 0x80, v=1, n=1, c=0; ADD 0xFF+0x01 -> 0x00, z=1, c=1, v=0.
REQ-041 The bench SHALL verify SLT: (0x0A, 0x0F) -> 0x01; (0x0F, 0x0A) -> 0x00; (0x80, 0x01) -> 0x01.
REQ-042 The bench SHALL verify MUL: 0x0A*0x03 -> in_ready=0 for 8 cycles, out_valid rises 9 cycles after acceptance with result 0x1E, c=0; 0x10*0x10 -> 0x00, z=1, c=1.
REQ-043 The bench SHALL verify backpressure: out_ready=0 for 5 cycles after ADD -> result held stable and in_ready=0; MUL completing while blocked -> MUL_WAIT, then loads on the edge after out_ready=1.
REQ-044 The bench SHALL verify reset mid-MUL (cycle 4) -> all outputs 0 immediately, no out_valid after release, and in_ready=1 on the first cycle after release; WIDTH=16 MUL 0x0100*0x0100 -> 0x0000, c=1, latency 17.

Source files
------------

// File: rtl/alu_pipe.sv
// Pipelined ALU with a one-cycle result register and an iterative shift-add multiplier.
// Valid/ready on both sides; MUL blocks new input until its product is in the output register.
module alu_pipe #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    MUL_RUN,
    MUL_WAIT
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_NAND = 3'b101,
    OP_SLT  = 3'b110,
    OP_MUL  = 3'b111
  } op_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [2*WIDTH-1:0] mul_prod;

  logic               out_free;
  logic               accept;
  logic               is_mul;
  logic               last_iter;
  logic               alu_load;
  logic               mul_load;

  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   diff;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_v;
  logic [WIDTH-1:0]   ld_res;
  logic               ld_c;
  logic               ld_v;

  assign out_free  = !out_valid || out_ready;
  assign is_mul    = (op_t'(op) == OP_MUL);
  assign accept    = in_valid && in_ready;
  assign alu_load  = accept && !is_mul;
  assign last_iter = (state == MUL_RUN) && (cnt == CW'(WIDTH - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (accept && is_mul) state_nxt = MUL_RUN;
      end
      MUL_RUN: begin
        if (last_iter) state_nxt = out_free ? IDLE : MUL_WAIT;
      end
      MUL_WAIT: begin
        if (out_free) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready = 1'b0;
    mul_load = 1'b0;
    case (state)
      IDLE:     in_ready = rst_n && out_free;
      MUL_RUN:  mul_load = last_iter && out_free;
      MUL_WAIT: mul_load = out_free;
      default: begin
        in_ready = 1'b0;
        mul_load = 1'b0;
      end
    endcase
  end

  // One partial product per MUL_RUN cycle: multiplicand shifts up, multiplier shifts down
  assign prod_nxt = acc + (mplier[0] ? mcand : '0);
  assign mul_prod = (state == MUL_WAIT) ? acc : prod_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && is_mul) begin
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
          end
        end
        MUL_RUN: begin
          acc    <= prod_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= last_iter ? '0 : cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = a - b;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (op_t'(op))
      OP_ADD: begin
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = diff;
        alu_c   = (a < b);
        alu_v   = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_XOR:  alu_res = a ^ b;
      OP_NAND: alu_res = ~(a & b);
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      default: alu_res = '0;
    endcase
  end

  // alu_load only occurs in IDLE and mul_load never does, so the two never collide
  always_comb begin
    ld_res = alu_res;
    ld_c   = alu_c;
    ld_v   = alu_v;
    if (mul_load) begin
      ld_res = mul_prod[WIDTH-1:0];
      ld_c   = |mul_prod[2*WIDTH-1:WIDTH];
      ld_v   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      flag_z    <= 1'b0;
      flag_n    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
    end else if (alu_load || mul_load) begin
      out_valid <= 1'b1;
      result    <= ld_res;
      flag_z    <= (ld_res == '0);
      flag_n    <= ld_res[WIDTH-1];
      flag_c    <= ld_c;
      flag_v    <= ld_v;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
